// File: rtl/bus_select_mux_pkg.sv
// Shared defaults and helpers for bus_select_mux instances.
package bus_select_mux_pkg;

    localparam int DEF_BUS_SIZE     = 32;
    localparam int DEF_BITS_ENABLES = 1;

    typedef logic [31:0] word_t;

    // Largest number of slices a select of the given width can address.
    function automatic int num_slices(input int bits);
        return 1 << bits;
    endfunction

endpackage

// File: rtl/bus_select_mux.sv
// N-way binary-select bus mux; out-of-range select yields zero data and o_sel_err.
// Define BUS_SELECT_MUX_REG_OUT_EN to register the outputs (1-cycle latency, sync reset).
module bus_select_mux
    import bus_select_mux_pkg::*;
#(
    parameter int BITS_ENABLES = DEF_BITS_ENABLES,
    parameter int BUS_SIZE     = DEF_BUS_SIZE,
    parameter int NUM_INPUTS   = num_slices(BITS_ENABLES)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [BITS_ENABLES-1:0]          i_en,
    input  logic [BUS_SIZE*NUM_INPUTS-1:0]   i_data,
    output logic [BUS_SIZE-1:0]              o_data,
    output logic                             o_sel_err
);

    if (NUM_INPUTS > num_slices(BITS_ENABLES) || NUM_INPUTS < 2) begin : g_bad_num_inputs
        $fatal(1, "bus_select_mux: NUM_INPUTS out of range 2..2**BITS_ENABLES");
    end
    if (BUS_SIZE < 1) begin : g_bad_bus_size
        $fatal(1, "bus_select_mux: BUS_SIZE must be >= 1");
    end

    logic [NUM_INPUTS-1:0][BUS_SIZE-1:0] slices;
    logic [BUS_SIZE-1:0]                 data_d;
    logic                                sel_err_d;

    for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_slice
        assign slices[k] = i_data[k*BUS_SIZE +: BUS_SIZE];
    end

    // Default covers out-of-range and X/Z selects: zero data, error flagged.
    always_comb begin
        data_d    = '0;
        sel_err_d = 1'b1;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (i_en == BITS_ENABLES'(k)) begin
                data_d    = slices[k];
                sel_err_d = 1'b0;
            end
        end
    end

`ifdef BUS_SELECT_MUX_REG_OUT_EN
    logic [BUS_SIZE-1:0] data_q;
    logic                sel_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign o_data    = data_q;
    assign o_sel_err = sel_err_q;
`else
    // Clock and reset only matter for the registered build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign o_data    = data_d;
    assign o_sel_err = sel_err_d;
`endif

endmodule

// File: tb/tb_bus_select_mux.sv
// Scoreboard bench for bus_select_mux across three parameterisations.
// Follows BUS_SELECT_MUX_REG_OUT_EN to pick combinational or registered timing.
module tb_bus_select_mux;
    import bus_select_mux_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [0:0]  en0 = '0;
    logic [63:0] data0 = '0;
    word_t       out0;
    logic        err0;

    logic [1:0]  en1 = '0;
    logic [23:0] data1 = '0;
    logic [7:0]  out1;
    logic        err1;

    logic [2:0]  en2 = '0;
    logic [63:0] data2 = '0;
    logic [7:0]  out2;
    logic        err2;

    always #5 clk = ~clk;

    bus_select_mux #(.BITS_ENABLES(1), .BUS_SIZE(32)) u_mux0 (
        .clk(clk), .rst(rst), .i_en(en0), .i_data(data0), .o_data(out0), .o_sel_err(err0));
    bus_select_mux #(.BITS_ENABLES(2), .BUS_SIZE(8), .NUM_INPUTS(3)) u_mux1 (
        .clk(clk), .rst(rst), .i_en(en1), .i_data(data1), .o_data(out1), .o_sel_err(err1));
    bus_select_mux #(.BITS_ENABLES(3), .BUS_SIZE(8)) u_mux2 (
        .clk(clk), .rst(rst), .i_en(en2), .i_data(data2), .o_data(out2), .o_sel_err(err2));

    typedef struct {
        string       tag;
        int          dut;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    localparam logic [23:0] D1_FIX = 24'h33_22_11;
    localparam logic [63:0] D2_FIX = 64'h77_66_55_44_33_22_11_00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m0(input logic e, input logic [63:0] d);
        return e ? d[63:32] : d[31:0];
    endfunction

    function automatic logic [7:0] m1(input logic [1:0] e, input logic [23:0] d);
        case (e)
            2'd0:    return d[7:0];
            2'd1:    return d[15:8];
            2'd2:    return d[23:16];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] m2(input logic [2:0] e, input logic [63:0] d);
        return d[int'(e)*8 +: 8];
    endfunction

    task automatic push(input string tag, input int dut, input logic [31:0] d, input logic e);
        exp_t x;
        x.tag = tag; x.dut = dut; x.data = d; x.err = e;
`ifdef BUS_SELECT_MUX_REG_OUT_EN
        if (rst) begin
            x.data = '0;
            x.err  = 1'b0;
        end
`endif
        sb.push_back(x);
    endtask

    task automatic settle_and_check();
        exp_t x;
`ifdef BUS_SELECT_MUX_REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
        while (sb.size() > 0) begin
            x = sb.pop_front();
            case (x.dut)
                0: begin
                    check({x.tag, "_d0"}, out0, x.data);
                    check({x.tag, "_e0"}, 32'(err0), 32'(x.err));
                end
                1: begin
                    check({x.tag, "_d1"}, 32'(out1), x.data);
                    check({x.tag, "_e1"}, 32'(err1), 32'(x.err));
                end
                default: begin
                    check({x.tag, "_d2"}, 32'(out2), x.data);
                    check({x.tag, "_e2"}, 32'(err2), 32'(x.err));
                end
            endcase
        end
    endtask

    // Drive all three muxes on the falling edge and queue the model results.
    task automatic apply(input string tag,
                         input logic [0:0] e0, input logic [63:0] d0,
                         input logic [1:0] e1, input logic [23:0] d1,
                         input logic [2:0] e2, input logic [63:0] d2);
        @(negedge clk);
        en0 = e0; data0 = d0;
        en1 = e1; data1 = d1;
        en2 = e2; data2 = d2;
        push(tag, 0, m0(e0, d0), 1'b0);
        push(tag, 1, 32'(m1(e1, d1)), e1 == 2'd3);
        push(tag, 2, 32'(m2(e2, d2)), 1'b0);
        settle_and_check();
    endtask

    initial begin
        // Reset held for two cycles; ignored by the combinational build.
        rst = 1'b1;
        for (int i = 0; i < 2; i++)
            apply("rst_hold", 1'b1, {32'hA5A5A5A5, 32'h1}, 2'd1, D1_FIX, 3'd5, D2_FIX);

        @(negedge clk);
        rst = 1'b0;
        en0 = 1'b1; data0 = {32'hA5A5A5A5, 32'h1};
`ifdef BUS_SELECT_MUX_REG_OUT_EN
        #1;
        check("reg_latency_before_edge", out0, 32'h0);
`endif
        push("rst_release", 0, 32'hA5A5A5A5, 1'b0);
        push("rst_release", 1, 32'(m1(en1, data1)), en1 == 2'd3);
        push("rst_release", 2, 32'(m2(en2, data2)), 1'b0);
        settle_and_check();

        apply("basic_en0", 1'b0, {32'hDEADBEEF, 32'h5}, 2'd0, D1_FIX, 3'd0, D2_FIX);
        apply("basic_en1", 1'b1, {32'hDEADBEEF, 32'h5}, 2'd1, D1_FIX, 3'd1, D2_FIX);

        apply("pc_sel0", 1'b0, {32'h7, 32'h5}, 2'd2, D1_FIX, 3'd2, D2_FIX);
        apply("pc_sel1", 1'b1, {32'h7, 32'h5}, 2'd3, D1_FIX, 3'd3, D2_FIX);
        apply("pc_sel0b", 1'b0, {32'h7, 32'h5}, 2'd0, D1_FIX, 3'd4, D2_FIX);

        for (int i = 0; i < 8; i++)
            apply("sweep", 1'(i), {32'hDEADBEEF, 32'h5}, 2'(i), D1_FIX, 3'(i), D2_FIX);

        // Reset landing on the same edge as a select change must win.
        apply("pre_rst", 1'b0, {32'hA5A5A5A5, 32'h1}, 2'd0, D1_FIX, 3'd6, D2_FIX);
        rst = 1'b1;
        apply("rst_with_sel", 1'b1, {32'hA5A5A5A5, 32'h1}, 2'd2, D1_FIX, 3'd7, D2_FIX);
        rst = 1'b0;
        apply("post_rst", 1'b1, {32'hA5A5A5A5, 32'h1}, 2'd2, D1_FIX, 3'd7, D2_FIX);

        for (int i = 0; i < 24; i++)
            apply("random", 1'($urandom_range(0, 1)), {$urandom, $urandom},
                  2'($urandom_range(0, 3)), 24'($urandom),
                  3'($urandom_range(0, 7)), {$urandom, $urandom});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
